// File: rtl/ctr_pkg.sv
`default_nettype none
// ctr_pkg: terminal-mode encodings and control FSM states for prog_updown_counter.
package ctr_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RELOAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : ctr_pkg
`default_nettype wire

// File: rtl/ctr_next_value.sv
`default_nettype none
// ctr_next_value: terminal detection and the count value one enabled step would produce.
module ctr_next_value
  import ctr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] reload_reg,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  output logic             at_term,
  output logic [WIDTH-1:0] next_count
);

  // >= so a limit lowered below the running count still terminates instead of wrapping.
  assign at_term = up_dn ? (count >= limit) : (count == '0);

  always_comb begin
    next_count = count;
    if (!at_term) begin
      next_count = up_dn ? (count + WIDTH'(1)) : (count - WIDTH'(1));
    end else begin
      case (mode)
        MODE_WRAP:    next_count = up_dn ? '0 : limit;
        MODE_SAT:     next_count = count;
        MODE_ONESHOT: next_count = count;
        MODE_RELOAD:  next_count = reload_reg;
        default:      next_count = count;
      endcase
    end
  end

endmodule : ctr_next_value
`default_nettype wire

// File: rtl/prog_updown_counter.sv
`default_nettype none
// prog_updown_counter: loadable up/down counter with programmable terminal value,
// four terminal modes, run/idle/done control, cascade carry and registered tc pulse.
module prog_updown_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             tc_pulse,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic [WIDTH-1:0] next_count;
  logic             at_term;

  ctr_next_value #(.WIDTH(WIDTH)) u_next (
    .count      (count),
    .limit      (limit),
    .reload_reg (reload_reg),
    .up_dn      (up_dn),
    .mode       (mode),
    .at_term    (at_term),
    .next_count (next_count)
  );

  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);
  assign carry = busy & en & at_term;

  // stop outranks start even outside RUN, so a simultaneous start/stop never launches a run.
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    if (ld) begin
      count_n  = ld_data;
      reload_n = ld_data;
      if (state != S_RUN) state_n = S_IDLE;
    end else if (stop) begin
      if (state == S_RUN) state_n = S_IDLE;
    end else if (start && state != S_RUN) begin
      state_n = S_RUN;
    end else if (state == S_RUN && en) begin
      count_n = next_count;
      if (at_term && mode == MODE_ONESHOT) state_n = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc_pulse   <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      tc_pulse   <= carry;
    end
  end

endmodule : prog_updown_counter
`default_nettype wire

// File: tb/tb_prog_updown_counter.sv
`default_nettype none
// tb_prog_updown_counter: directed scenarios plus randomized traffic against a behavioural model.
module tb_prog_updown_counter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, ld, start, stop, en, up_dn;
  logic [W-1:0] ld_data, limit, count;
  logic [1:0]   mode;
  logic         carry, tc_pulse, busy, done;

  prog_updown_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ld(ld), .ld_data(ld_data), .start(start), .stop(stop),
    .en(en), .up_dn(up_dn), .mode(mode), .limit(limit), .count(count),
    .carry(carry), .tc_pulse(tc_pulse), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 running, 2 finished.
  int m_count, m_reload, m_phase, m_tc;
  bit m_valid = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reached_end(int c, int lim, bit up);
    return up ? (c >= lim) : (c == 0);
  endfunction

  task automatic step(input bit r, input bit l, input int d, input bit s, input bit p,
                      input bit e, input bit u, input int md, input int lim);
    int  exp_carry;
    bit  term;
    rst = r; ld = l; ld_data = d[W-1:0]; start = s; stop = p;
    en = e; up_dn = u; mode = md[1:0]; limit = lim[W-1:0];
    #1;
    term      = reached_end(m_count, lim, u);
    exp_carry = (m_phase == 1 && e && term) ? 1 : 0;
    if (m_valid) chk("carry", {31'd0, carry}, exp_carry);
    if (r) begin
      m_count = 0; m_reload = 0; m_phase = 0; m_tc = 0; m_valid = 1;
    end else begin
      m_tc = exp_carry;
      if (l) begin
        m_count = d; m_reload = d;
        if (m_phase != 1) m_phase = 0;
      end else if (p) begin
        if (m_phase == 1) m_phase = 0;
      end else if (s && m_phase != 1) begin
        m_phase = 1;
      end else if (m_phase == 1 && e) begin
        if (!term) m_count = u ? m_count + 1 : m_count - 1;
        else if (md == 0) m_count = u ? 0 : lim;
        else if (md == 3) m_count = m_reload;
        else if (md == 2) m_phase = 2;
      end
    end
    @(posedge clk);
    #1;
    chk("count", {28'd0, count}, m_count);
    chk("busy", {31'd0, busy}, (m_phase == 1) ? 1 : 0);
    chk("done", {31'd0, done}, (m_phase == 2) ? 1 : 0);
    chk("tc_pulse", {31'd0, tc_pulse}, m_tc);
  endtask

  initial begin
    rst = 1; ld = 0; ld_data = '0; start = 0; stop = 0; en = 0; up_dn = 1; mode = 2'b00; limit = '0;
    @(posedge clk); #1;

    // 1: wrap up to 5
    step(1, 0, 0, 0, 0, 0, 1, 0, 5);
    chk("reset_count", {28'd0, count}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0, 5);
    step(0, 0, 0, 1, 0, 1, 1, 0, 5);
    chk("t1_start_nostep", {28'd0, count}, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 1, 0, 5);
    chk("t1_wrapped", {28'd0, count}, 0);
    chk("t1_tc", {31'd0, tc_pulse}, 1);

    // 2: wrap down, limit 9
    step(0, 1, 3, 0, 0, 0, 0, 0, 9);
    step(0, 0, 0, 1, 0, 0, 0, 0, 9);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 9);
    chk("t2_down_wrap", {28'd0, count}, 8);

    // 3: saturate at 15
    step(0, 1, 13, 0, 0, 0, 1, 1, 15);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 1, 1, 15);
    chk("t3_sat", {28'd0, count}, 15);
    chk("t3_tc_repeat", {31'd0, tc_pulse}, 1);

    // 4: one-shot to 4, then restart at terminal
    step(0, 1, 0, 0, 0, 0, 1, 2, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 1, 2, 4);
    chk("t4_done", {31'd0, done}, 1);
    chk("t4_hold", {28'd0, count}, 4);
    step(0, 0, 0, 1, 0, 1, 1, 2, 4);
    chk("t4_restart_busy", {31'd0, busy}, 1);
    step(0, 0, 0, 0, 1, 1, 1, 2, 4);

    // 5: reload from 2, limit 6, then reset mid-run
    step(0, 1, 2, 0, 0, 0, 1, 3, 6);
    step(0, 0, 0, 1, 0, 0, 1, 3, 6);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 1, 3, 6);
    chk("t5_reloaded", {28'd0, count}, 3);
    step(1, 0, 0, 0, 0, 1, 1, 3, 6);
    chk("t5_rst_tc", {31'd0, tc_pulse}, 0);

    // 6: ld+start together stays idle; en low holds
    step(0, 1, 7, 1, 0, 1, 1, 0, 12);
    chk("t6_ld_wins", {31'd0, busy}, 0);
    step(0, 0, 0, 1, 0, 1, 1, 0, 12);
    step(0, 0, 0, 0, 0, 1, 1, 0, 12);
    step(0, 0, 0, 0, 0, 0, 1, 0, 12);
    chk("t6_en_hold", {28'd0, count}, 8);

    // randomized traffic; limit/mode drift occasionally, including mid-run lowering
    begin
      int lim = 9, md = 0;
      bit up = 1;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 9) == 0) lim = $urandom_range(0, MAX);
        if ($urandom_range(0, 14) == 0) md = $urandom_range(0, 3);
        if ($urandom_range(0, 19) == 0) up = ~up;
        step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, MAX),
             $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 9) != 0, up, md, lim);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prog_updown_counter
`default_nettype wire
